// File: rtl/processor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : processor_pkg
//  Description : State encodings, opcode classes and the data-phase enable
//                vector shared by the processor control unit and its decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package processor_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_RETIRE = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;
    localparam logic [2:0] ST_FAULT  = 3'd7;

    localparam logic [7:0] CLS_ALU_RD     = 8'h22;
    localparam logic [7:0] CLS_RAM_RD     = 8'h42;
    localparam logic [7:0] CLS_RAM_WR_IMM = 8'h41;
    localparam logic [7:0] CLS_ROM_RAM    = 8'h31;
    localparam logic [7:0] CLS_RAM_ALU    = 8'h92;
    localparam logic [3:0] ALU_OP         = 4'h1;
    localparam logic [3:0] PC_OP          = 4'h7;

    typedef struct packed {
        logic rom_data_en;
        logic ram_read_en;
        logic ram_write_en;
        logic alu_read_en;
        logic alu_write_en;
    } bus_en_t;

    localparam int BUS_EN_WIDTH = $bits(bus_en_t);

endpackage
`default_nettype wire

// File: rtl/opcode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_decoder
//  Description : Combinational decode of a latched opcode into data-phase bus
//                enables plus memory-class and halt flags.
//  Revision    : 1.0  initial release
// ============================================================================
module opcode_decoder
    import processor_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] i_opcode,
    output bus_en_t               o_bus_en,
    output logic                  o_is_mem,
    output logic                  o_is_halt
);

    logic [7:0] w_cls;

    assign w_cls     = i_opcode[DATA_WIDTH-1 -: 8];
    assign o_is_halt = (i_opcode == '0);

    always_comb begin
        o_bus_en = '0;
        o_is_mem = 1'b0;
        case (w_cls)
            CLS_ALU_RD: begin
                o_bus_en.alu_read_en = 1'b1;
            end
            CLS_RAM_RD: begin
                o_bus_en.ram_read_en = 1'b1;
                o_is_mem             = 1'b1;
            end
            CLS_RAM_WR_IMM: begin
                o_bus_en.ram_write_en = 1'b1;
                o_is_mem              = 1'b1;
            end
            CLS_ROM_RAM: begin
                o_bus_en.rom_data_en  = 1'b1;
                o_bus_en.ram_write_en = 1'b1;
                o_is_mem              = 1'b1;
            end
            CLS_RAM_ALU: begin
                o_bus_en.ram_read_en  = 1'b1;
                o_bus_en.alu_write_en = 1'b1;
                o_is_mem              = 1'b1;
            end
            default: begin
                // PC ops need nothing here: the pc picks up the opcode at pc_en.
                if (w_cls[7:4] == ALU_OP) begin
                    o_bus_en.alu_write_en = 1'b1;
                end else if (w_cls[7:4] == PC_OP) begin
                    o_bus_en = '0;
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/processor_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : processor_control_unit
//  Description : Fetch-decode-execute sequencer with memory wait/timeout,
//                single-step, sticky HALT/FAULT and retired-instruction count.
//  Revision    : 1.0  initial release
// ============================================================================
module processor_control_unit
    import processor_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int EXEC_CYCLES  = 2,
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  step_mode,
    input  logic                  step_req,
    input  logic [DATA_WIDTH-1:0] opcode,
    input  logic                  mem_ready,
    output logic                  pc_read_en,
    output logic                  rom_en,
    output logic                  rom_data_en,
    output logic                  ram_read_en,
    output logic                  ram_write_en,
    output logic                  alu_read_en,
    output logic                  alu_write_en,
    output logic                  pc_en,
    output logic [2:0]            state,
    output logic                  halted,
    output logic                  fault,
    output logic [CNT_WIDTH-1:0]  instr_count
);

    localparam logic [3:0]  EXEC_LAST  = (EXEC_CYCLES == 0) ? 4'd0 : 4'(EXEC_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(WAIT_TIMEOUT - 1);
    localparam logic [2:0]  AFTER_DATA = (EXEC_CYCLES == 0) ? ST_RETIRE : ST_EXEC;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [DATA_WIDTH-1:0] r_opcode_q;
    logic [3:0]            r_exec_cnt;
    logic [15:0]           r_wait_cnt;
    logic [CNT_WIDTH-1:0]  r_instr_count;
    bus_en_t               w_bus_en;
    logic                  w_is_mem;
    logic                  w_is_halt;
    logic                  w_continue;
    logic                  w_launch;

    opcode_decoder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decoder (
        .i_opcode  (r_opcode_q),
        .o_bus_en  (w_bus_en),
        .o_is_mem  (w_is_mem),
        .o_is_halt (w_is_halt)
    );

    assign w_continue = ~step_mode & run;
    assign w_launch   = w_continue | (step_mode & step_req);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_launch) w_state_next = ST_FETCH;
            ST_FETCH:  w_state_next = ST_DECODE;
            ST_DECODE: begin
                if (w_is_halt)                  w_state_next = ST_HALT;
                else if (w_is_mem && !mem_ready) w_state_next = ST_WAIT;
                else                             w_state_next = AFTER_DATA;
            end
            // A late acknowledge on the final allowed cycle still wins.
            ST_WAIT: begin
                if (mem_ready)                    w_state_next = AFTER_DATA;
                else if (r_wait_cnt == WAIT_LAST) w_state_next = ST_FAULT;
            end
            ST_EXEC:   if (r_exec_cnt == EXEC_LAST) w_state_next = ST_RETIRE;
            ST_RETIRE: w_state_next = w_continue ? ST_FETCH : ST_IDLE;
            default:   w_state_next = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_opcode_q    <= '0;
            r_exec_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_instr_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_exec_cnt <= (r_state == ST_EXEC) ? r_exec_cnt + 4'd1 : 4'd0;
            r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 16'd1 : 16'd0;
            if (r_state == ST_FETCH) begin
                r_opcode_q <= opcode;
            end
            if (r_state == ST_RETIRE) begin
                r_instr_count <= r_instr_count + CNT_WIDTH'(1);
            end
        end
    end

    // Outputs depend only on registered state, so they are glitch-free and drop with reset.
    always_comb begin
        pc_read_en   = 1'b0;
        rom_en       = 1'b0;
        rom_data_en  = 1'b0;
        ram_read_en  = 1'b0;
        ram_write_en = 1'b0;
        alu_read_en  = 1'b0;
        alu_write_en = 1'b0;
        pc_en        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                pc_read_en = 1'b1;
                rom_en     = 1'b1;
            end
            ST_DECODE, ST_WAIT: begin
                rom_data_en  = w_bus_en.rom_data_en;
                ram_read_en  = w_bus_en.ram_read_en;
                ram_write_en = w_bus_en.ram_write_en;
                alu_read_en  = w_bus_en.alu_read_en;
                alu_write_en = w_bus_en.alu_write_en;
            end
            ST_RETIRE: pc_en = 1'b1;
            default: pc_en = 1'b0;
        endcase
    end

    assign state       = r_state;
    assign halted      = (r_state == ST_HALT);
    assign fault       = (r_state == ST_FAULT);
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_processor_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_processor_control_unit
//  Description : Self-checking bench; per-instruction expected traces built
//                from the instruction timing rules, plus EXEC length variants.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_processor_control_unit;

    localparam int EXEC = 2;
    localparam int TO   = 4;

    // word layout: pc_read, rom, rom_data, ram_rd, ram_wr, alu_rd, alu_wr, pc_en, halted, fault
    localparam logic [9:0] W_FETCH  = 10'b11_00000_0_00;
    localparam logic [9:0] W_RETIRE = 10'b00_00000_1_00;
    localparam logic [9:0] W_HALT   = 10'b00_00000_0_10;
    localparam logic [9:0] W_FAULT  = 10'b00_00000_0_01;

    logic clk = 1'b0;
    logic reset_n, run, step_mode, step_req, mem_ready, run_x;
    logic [15:0] rom [0:63];
    logic [5:0]  pc;
    logic [15:0] opcode;
    logic [15:0] op_x;
    wire  [9:0]  w_word, e0_w, e7_w;
    wire  [2:0]  w_state, e0_state, e7_state;
    wire  [31:0] w_count, e0_cnt, e7_cnt;

    int checks = 0;
    int errors = 0;
    int count_m = 0;

    always #5 clk = ~clk;

    assign opcode = rom[pc];
    assign op_x   = 16'h1555;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       pc <= 6'd0;
        else if (w_word[2]) pc <= pc + 6'd1;
    end

    processor_control_unit #(.DATA_WIDTH(16), .EXEC_CYCLES(EXEC), .WAIT_TIMEOUT(TO), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step_mode(step_mode), .step_req(step_req),
        .opcode(opcode), .mem_ready(mem_ready),
        .pc_read_en(w_word[9]), .rom_en(w_word[8]), .rom_data_en(w_word[7]), .ram_read_en(w_word[6]),
        .ram_write_en(w_word[5]), .alu_read_en(w_word[4]), .alu_write_en(w_word[3]), .pc_en(w_word[2]),
        .state(w_state), .halted(w_word[1]), .fault(w_word[0]), .instr_count(w_count)
    );

    processor_control_unit #(.DATA_WIDTH(16), .EXEC_CYCLES(0), .WAIT_TIMEOUT(255), .CNT_WIDTH(32)) u_e0 (
        .clk(clk), .reset_n(reset_n), .run(run_x), .step_mode(1'b0), .step_req(1'b0),
        .opcode(op_x), .mem_ready(mem_ready),
        .pc_read_en(e0_w[9]), .rom_en(e0_w[8]), .rom_data_en(e0_w[7]), .ram_read_en(e0_w[6]),
        .ram_write_en(e0_w[5]), .alu_read_en(e0_w[4]), .alu_write_en(e0_w[3]), .pc_en(e0_w[2]),
        .state(e0_state), .halted(e0_w[1]), .fault(e0_w[0]), .instr_count(e0_cnt)
    );

    processor_control_unit #(.DATA_WIDTH(16), .EXEC_CYCLES(7), .WAIT_TIMEOUT(255), .CNT_WIDTH(32)) u_e7 (
        .clk(clk), .reset_n(reset_n), .run(run_x), .step_mode(1'b0), .step_req(1'b0),
        .opcode(op_x), .mem_ready(mem_ready),
        .pc_read_en(e7_w[9]), .rom_en(e7_w[8]), .rom_data_en(e7_w[7]), .ram_read_en(e7_w[6]),
        .ram_write_en(e7_w[5]), .alu_read_en(e7_w[4]), .alu_write_en(e7_w[3]), .pc_en(e7_w[2]),
        .state(e7_state), .halted(e7_w[1]), .fault(e7_w[0]), .instr_count(e7_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {is_mem, rom_data, ram_rd, ram_wr, alu_rd, alu_wr} straight from the class table
    function automatic logic [5:0] spec_class(input logic [15:0] op);
        case (op[15:8])
            8'h22:   return 6'b0_00010;
            8'h42:   return 6'b1_01000;
            8'h41:   return 6'b1_00100;
            8'h31:   return 6'b1_10100;
            8'h92:   return 6'b1_01001;
            default: return (op[15:12] == 4'h1) ? 6'b0_00001 : 6'b0_00000;
        endcase
    endfunction

    function automatic logic [15:0] rand_op();
        logic [7:0] lo;
        lo = 8'($urandom);
        case ($urandom_range(0, 8))
            0:       return {8'h22, lo};
            1:       return {8'h42, lo};
            2:       return {8'h41, lo};
            3:       return {8'h31, lo};
            4:       return {8'h92, lo};
            5:       return {4'h1, 4'($urandom), lo};
            6:       return {4'h7, 4'($urandom), lo};
            7:       return {8'hAB, lo};
            default: return {8'h00, lo | 8'h01};
        endcase
    endfunction

    // Starts in the FETCH cycle; delay = cycles mem_ready stays low from DECODE on.
    task automatic do_instr(input logic [15:0] op, input int delay, input int step_c, input int drop_c);
        logic [5:0] cls;
        logic [9:0] exp;
        logic       mem, hlt, flt;
        int         n_en, total;
        cls   = spec_class(op);
        mem   = cls[5];
        hlt   = (op == 16'h0000);
        flt   = mem && (delay > TO);
        n_en  = mem ? ((flt ? TO : delay) + 1) : 1;
        total = (flt || hlt) ? (1 + n_en) : (1 + n_en + EXEC + 1);
        rom[pc] = op;
        for (int c = 0; c < total; c++) begin
            if (mem && c >= 1 && c <= n_en) mem_ready = (c == 1 + delay);
            else                            mem_ready = 1'($urandom_range(0, 1));
            step_req = (c == step_c);
            if (c == drop_c) run = 1'b0;
            if (c == 0)                 exp = W_FETCH;
            else if (c <= n_en)         exp = {2'b00, cls[4:0], 3'b000};
            else if (c <= n_en + EXEC)  exp = 10'b0;
            else                        exp = W_RETIRE;
            check($sformatf("op%04h_c%0d", op, c), 32'(w_word), 32'(exp));
            tick();
        end
        step_req = 1'b0;
        if (!flt && !hlt) count_m++;
        check($sformatf("count_after_%04h", op), w_count, 32'(count_m));
    endtask

    task automatic check_idle(input int n);
        run = 1'b0;
        step_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            check("idle_word", 32'(w_word), 32'd0);
            check("idle_state", 32'(w_state), 32'd0);
            tick();
        end
    endtask

    task automatic sticky(input string tag, input logic [9:0] exp_w, input logic [2:0] exp_s, input int n);
        for (int i = 0; i < n; i++) begin
            run       = 1'($urandom_range(0, 1));
            step_req  = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            check({tag, "_word"}, 32'(w_word), 32'(exp_w));
            check({tag, "_state"}, 32'(w_state), 32'(exp_s));
            check({tag, "_count"}, w_count, 32'(count_m));
            tick();
        end
        run = 1'b0;
        step_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0;
        step_req = 1'b0;
        step_mode = 1'b0;
        tick();
        reset_n = 1'b1;
        count_m = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0_ret, e7_ret, e0_n, e7_n;
        reset_n = 1'b1; run = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        mem_ready = 1'b0; run_x = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        #2 reset_n = 1'b0;
        tick();
        tick();
        check("reset_word", 32'(w_word), 32'd0);
        check("reset_state", 32'(w_state), 32'd0);
        check("reset_count", w_count, 32'd0);
        reset_n = 1'b1;
        check_idle(3);

        // continuous run: directed cases, then random
        run = 1'b1;
        tick();
        do_instr(16'h2200, 0, -1, -1);
        do_instr(16'h4105, 3, -1, -1);
        do_instr(16'h4200, TO, -1, -1);
        do_instr(16'hAB12, 0, -1, -1);
        do_instr(16'h9200, 0, -1, -1);
        for (int i = 0; i < 30; i++) begin
            logic [15:0] op;
            op = rand_op();
            do_instr(op, $urandom_range(0, TO), -1, -1);
        end
        do_instr(16'h1234, 0, -1, 2);
        check_idle(3);

        // single-step with a stray pulse mid-instruction
        step_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            tick();
            do_instr({4'h1, 12'($urandom)}, 0, (i == 1) ? 4 : 2, -1);
            check_idle(6);
        end
        step_mode = 1'b0;

        // HALT is sticky and does not count
        run = 1'b1;
        tick();
        do_instr(16'h2200, 0, -1, -1);
        do_instr(16'h0000, 0, -1, -1);
        sticky("halt", W_HALT, 3'd6, 5);

        // timeout into FAULT
        do_reset();
        run = 1'b1;
        tick();
        do_instr(16'h4200, TO + 1, -1, -1);
        sticky("fault", W_FAULT, 3'd7, 5);

        // reset in the WAIT of a rom->ram move
        do_reset();
        run = 1'b1;
        tick();
        do_instr(16'h2200, 0, -1, -1);
        rom[pc] = 16'h3100;
        mem_ready = 1'b0;
        check("mid_fetch", 32'(w_word), 32'(W_FETCH));
        tick();
        tick();
        check("mid_wait_word", 32'(w_word), 32'(10'b00_10100_000));
        check("mid_wait_state", 32'(w_state), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("mid_reset_word", 32'(w_word), 32'd0);
        check("mid_reset_state", 32'(w_state), 32'd0);
        check("mid_reset_count", w_count, 32'd0);
        tick();
        reset_n = 1'b1;
        count_m = 0;
        run = 1'b1;
        tick();
        do_instr(16'h3100, 1, -1, -1);
        do_instr(16'h4105, 3, -1, -2);
        run = 1'b0;
        tick();
        tick();

        // EXEC_CYCLES = 0 and 7 latency
        run_x = 1'b1;
        tick();
        run_x = 1'b0;
        e0_ret = -1; e7_ret = -1; e0_n = 0; e7_n = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 1) begin
                check("e0_decode", 32'(e0_w), 32'(10'b00_00001_000));
                check("e7_decode", 32'(e7_w), 32'(10'b00_00001_000));
            end
            if (e0_w[2]) begin e0_n++; if (e0_ret < 0) e0_ret = c; end
            if (e7_w[2]) begin e7_n++; if (e7_ret < 0) e7_ret = c; end
            tick();
        end
        check("e0_latency", 32'(e0_ret + 1), 32'd3);
        check("e7_latency", 32'(e7_ret + 1), 32'd10);
        check("e0_retires", 32'(e0_n), 32'd1);
        check("e7_retires", 32'(e7_n), 32'd1);
        check("e0_count", e0_cnt, 32'd1);
        check("e7_count", e7_cnt, 32'd1);
        check("e0_idle", 32'(e0_state), 32'd0);
        check("e7_idle", 32'(e7_state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
